cond_exec_stage: RTL

COND_EXEC_STAGE -- requirements
Module: cond_exec_stage

---
 rtl/cond_exec_stage_pkg.sv | 59 +++++
 rtl/cond_exec_stage_cond_check.sv | 41 ++++
 rtl/cond_exec_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/cond_exec_stage_pkg.sv
// Shared definitions for the conditional-execute stage: ALU operation codes,
// condition-code encodings and the execute-register layout.
package cond_exec_stage_pkg;

  // ALU operation codes produced by the decoder
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_AND = 4'b0101;
  localparam logic [3:0] ALU_ORR = 4'b0111;
  localparam logic [3:0] ALU_EOR = 4'b1011;
  localparam logic [3:0] ALU_MVN = 4'b1101;

  // Instruction condition field encodings
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_code_e;

  // Architectural flags, MSB first: {N,Z,C,V}
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Everything the execute register captures from decode
  typedef struct packed {
    logic       valid;
    logic [3:0] cond;
    logic       s;
    logic       pcsrc;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [3:0] alucontrol;
  } ex_reg_t;

  // Only arithmetic operations produce meaningful carry and overflow
  function automatic logic alu_sets_cv(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/cond_exec_stage_cond_check.sv
// Purely combinational condition evaluator: decides whether an instruction
// with condition field cond_i executes given the current {N,Z,C,V} flags.
module cond_check
  import cond_exec_stage_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  nzcv_t      f;
  cond_code_e cc;

  assign f  = nzcv_t'(flags_i);
  assign cc = cond_code_e'(cond_i);

  // Map each condition code to its flag predicate
  always_comb begin
    pass_o = 1'b0;
    case (cc)
      COND_EQ: pass_o = f.z;
      COND_NE: pass_o = ~f.z;
      COND_CS: pass_o = f.c;
      COND_CC: pass_o = ~f.c;
      COND_MI: pass_o = f.n;
      COND_PL: pass_o = ~f.n;
      COND_VS: pass_o = f.v;
      COND_VC: pass_o = ~f.v;
      COND_HI: pass_o = f.c & ~f.z;
      COND_LS: pass_o = ~f.c | f.z;
      COND_GE: pass_o = (f.n == f.v);
      COND_LT: pass_o = (f.n != f.v);
      COND_GT: pass_o = ~f.z & (f.n == f.v);
      COND_LE: pass_o = f.z | (f.n != f.v);
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage condition logic: registers decode controls, evaluates the
// instruction condition against the architectural flags, gates the
// side-effecting controls and updates the flags register.
module cond_exec_stage
  import cond_exec_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid_d,
  input  logic       stall,
  input  logic       flush,
  input  logic [3:0] cond_d,
  input  logic       s_d,
  input  logic       pcsrc_d,
  input  logic       memtoreg_d,
  input  logic       we_d,
  input  logic       alusrc_d,
  input  logic       regwrite_d,
  input  logic [3:0] alucontrol_d,
  input  logic [3:0] aluflags,
  output logic       pcsrc_e,
  output logic       regwrite_e,
  output logic       memwrite_e,
  output logic       memtoreg_e,
  output logic       alusrc_e,
  output logic [3:0] alucontrol_e,
  output logic       condex_e,
  output logic       branch_taken_e,
  output logic [3:0] flags_q
);

  ex_reg_t    ex_q;
  ex_reg_t    ex_d;
  logic [3:0] flags_d;
  logic       cond_pass;
  logic       flag_we;

  cond_check u_cond_check (
    .cond_i  (ex_q.cond),
    .flags_i (flags_q),
    .pass_o  (cond_pass)
  );

  // Gating is combinational from the execute register and the pre-update flags
  assign condex_e       = ex_q.valid & cond_pass;
  assign pcsrc_e        = ex_q.pcsrc & condex_e;
  assign regwrite_e     = ex_q.regwrite & condex_e;
  assign memwrite_e     = ex_q.memwrite & condex_e;
  assign branch_taken_e = pcsrc_e;
  assign memtoreg_e     = ex_q.memtoreg;
  assign alusrc_e       = ex_q.alusrc;
  assign alucontrol_e   = ex_q.alucontrol;

  // A stalled instruction must not commit flags; it will retry next cycle
  assign flag_we = condex_e & ex_q.s & ~stall;

  // Next execute-register contents: flush bubbles, stall holds, else capture
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d.valid      = valid_d;
      ex_d.cond       = cond_d;
      ex_d.s          = s_d;
      ex_d.pcsrc      = pcsrc_d;
      ex_d.memtoreg   = memtoreg_d;
      ex_d.memwrite   = we_d;
      ex_d.alusrc     = alusrc_d;
      ex_d.regwrite   = regwrite_d;
      ex_d.alucontrol = alucontrol_d;
    end
  end

  // Next flags: N,Z always follow the ALU; C,V only for arithmetic ops
  always_comb begin
    flags_d = flags_q;
    if (flag_we) begin
      flags_d[3:2] = aluflags[3:2];
      if (alu_sets_cv(ex_q.alucontrol)) begin
        flags_d[1:0] = aluflags[1:0];
      end
    end
  end

  // Execute register and flags register, asynchronously cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q    <= '0;
      flags_q <= 4'b0000;
    end else begin
      ex_q    <= ex_d;
      flags_q <= flags_d;
    end
  end

endmodule
